// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped TX FIFO and RX capture register on a processor data bus
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk_t,
  input  logic        rst_t,
  input  logic [31:0] addr_t,
  input  logic [31:0] wr_data_t,
  input  logic        mem_wr_t,
  input  logic        mem_rd_t,
  output logic [31:0] rd_data_t,
  output logic        stall_t,
  output logic [31:0] mem_map_io_t,
  output logic        io_valid_t,
  input  logic        io_ready_t,
  input  logic [31:0] ext_in_t,
  input  logic        ext_in_valid_t
);
  localparam int AW = $clog2(TX_DEPTH);
  logic [31:0] off;
  logic in_win, is_tx, is_st, is_rx, is_cnt;
  logic [31:0] fifo [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [31:0] last_out, rx_reg;
  logic rx_valid, rx_ovr, full, empty, push, pop, rd_rx, ovr_set, ovr_clr;
  // BASE_ADDR is word aligned, so addr_t[1:0] cannot move an address across the 16-byte window edge
  assign off = addr_t - BASE_ADDR;
  assign in_win = off < 32'd16;
  assign is_tx = in_win && off[3:2] == 2'd0;
  assign is_st = in_win && off[3:2] == 2'd1;
  assign is_rx = in_win && off[3:2] == 2'd2;
  assign is_cnt = in_win && off[3:2] == 2'd3;
  assign full = count == (AW+1)'(TX_DEPTH);
  assign empty = count == '0;
  assign push = mem_wr_t && is_tx && !full;
  assign pop = !empty && io_ready_t;
  assign stall_t = mem_wr_t && is_tx && full;
  assign io_valid_t = !empty;
  assign mem_map_io_t = empty ? last_out : fifo[rd_ptr];
  assign rd_rx = mem_rd_t && is_rx;
  assign ovr_set = ext_in_valid_t && rx_valid && !rd_rx;
  assign ovr_clr = mem_wr_t && is_st && wr_data_t[3];
  // load data is purely combinational so a same-cycle store or pop is not yet visible
  always_comb
    rd_data_t = is_st ? {28'd0, rx_ovr, rx_valid, empty, full} :
                is_rx ? rx_reg :
                is_cnt ? 32'(count) : 32'd0;
  // storage needs no reset: occupancy alone decides which slots are live
  always_ff @(posedge clk_t)
    if (push) fifo[wr_ptr] <= wr_data_t;
  // FIFO pointers, occupancy and the last word handed to the consumer
  always_ff @(posedge clk_t or posedge rst_t)
    if (rst_t) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      last_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_out <= fifo[rd_ptr];
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // RX capture: a read in the same cycle frees the slot for the incoming word; a new overrun beats a clear
  always_ff @(posedge clk_t or posedge rst_t)
    if (rst_t) begin
      rx_reg <= '0;
      rx_valid <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      if (ext_in_valid_t && (!rx_valid || rd_rx)) begin
        rx_reg <= ext_in_t;
        rx_valid <= 1'b1;
      end else if (rd_rx) rx_valid <= 1'b0;
      rx_ovr <= ovr_set ? 1'b1 : ovr_clr ? 1'b0 : rx_ovr;
    end
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: scoreboard bench with a queue-based reference model of the IO port
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int D = 4;
  logic clk_t = 0, rst_t = 1;
  logic [31:0] addr_t = 0, wr_data_t = 0, ext_in_t = 0;
  logic mem_wr_t = 0, mem_rd_t = 0, io_ready_t = 0, ext_in_valid_t = 0;
  logic [31:0] rd_data_t, mem_map_io_t;
  logic stall_t, io_valid_t;
  always #5 clk_t = ~clk_t;
  mmio_port_responder #(.BASE_ADDR(BASE), .TX_DEPTH(D)) dut (
    .clk_t(clk_t), .rst_t(rst_t), .addr_t(addr_t), .wr_data_t(wr_data_t),
    .mem_wr_t(mem_wr_t), .mem_rd_t(mem_rd_t), .rd_data_t(rd_data_t), .stall_t(stall_t),
    .mem_map_io_t(mem_map_io_t), .io_valid_t(io_valid_t), .io_ready_t(io_ready_t),
    .ext_in_t(ext_in_t), .ext_in_valid_t(ext_in_valid_t)
  );
  typedef struct {logic [31:0] rd; logic [31:0] io; logic stall; logic valid;} exp_t;
  exp_t sb[$];
  logic [31:0] mq[$];
  logic [31:0] m_last = 0, m_rx = 0;
  logic m_rxv = 0, m_ovr = 0;
  int n_cmp = 0, n_bad = 0;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction
  // register index inside the window, or -1 outside it
  function automatic int rsel(logic [31:0] a);
    logic [31:0] o;
    o = (a & 32'hFFFF_FFFC) - BASE;
    return (o < 16) ? int'(o >> 2) : -1;
  endfunction
  function automatic logic [31:0] m_rd(logic [31:0] a);
    case (rsel(a))
      1: return {28'd0, m_ovr, m_rxv, mq.size() == 0, mq.size() == D};
      2: return m_rx;
      3: return mq.size();
      default: return 0;
    endcase
  endfunction
  function automatic void model_reset();
    mq.delete();
    m_last = 0; m_rx = 0; m_rxv = 0; m_ovr = 0;
  endfunction
  // one clock edge applied to the model using the inputs currently on the bus
  function automatic void model_step();
    int s;
    bit was_full, rd_rx;
    s = rsel(addr_t);
    was_full = mq.size() == D;
    rd_rx = mem_rd_t && s == 2;
    if (mq.size() != 0 && io_ready_t) m_last = mq.pop_front();
    if (mem_wr_t && s == 0 && !was_full) mq.push_back(wr_data_t);
    if (mem_wr_t && s == 1 && wr_data_t[3]) m_ovr = 0;
    if (ext_in_valid_t) begin
      if (!m_rxv || rd_rx) begin m_rx = ext_in_t; m_rxv = 1; end
      else m_ovr = 1;
    end else if (rd_rx) m_rxv = 0;
  endfunction
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic wr, input logic rd,
                     input logic rdy, input logic [31:0] ex, input logic exv);
    exp_t e;
    @(posedge clk_t); #1;
    model_step();
    addr_t = a; wr_data_t = wd; mem_wr_t = wr; mem_rd_t = rd;
    io_ready_t = rdy; ext_in_t = ex; ext_in_valid_t = exv;
    e.rd = m_rd(a);
    e.io = mq.size() != 0 ? mq[0] : m_last;
    e.stall = wr && rsel(a) == 0 && mq.size() == D;
    e.valid = mq.size() != 0;
    sb.push_back(e);
  endtask
  // asynchronous reset asserted between edges; outputs must react before any edge
  task automatic do_reset();
    @(negedge clk_t); #1;
    rst_t = 1;
    addr_t = BASE + 32'hC; mem_wr_t = 0; mem_rd_t = 0; io_ready_t = 0; ext_in_valid_t = 0;
    #1;
    chk("rst_io_valid", 32'(io_valid_t), 0);
    chk("rst_io_data", mem_map_io_t, 0);
    chk("rst_stall", 32'(stall_t), 0);
    chk("rst_count", rd_data_t, 0);
    addr_t = BASE + 32'h4;
    #1;
    chk("rst_status", rd_data_t, 32'h2);
    model_reset();
    @(posedge clk_t); #3;
    rst_t = 0;
  endtask
  always @(negedge clk_t)
    if (sb.size() != 0) begin : mon
      exp_t e;
      e = sb.pop_front();
      chk("rd_data", rd_data_t, e.rd);
      chk("io_data", mem_map_io_t, e.io);
      chk("stall", 32'(stall_t), 32'(e.stall));
      chk("io_valid", 32'(io_valid_t), 32'(e.valid));
    end
  initial begin
    logic [31:0] a;
    do_reset();
    foreach (mq[i]) ;
    for (int i = 1; i <= 4; i++) cyc(BASE, 32'h11 * i, 1, 0, 0, 0, 0);
    cyc(BASE, 32'h55, 1, 0, 0, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 0, 0, 0);
    cyc(BASE + 32'h4, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(BASE + 32'hC, 0, 0, 1, 1, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 0, 0, 0);
    cyc(BASE, 32'h66, 1, 0, 0, 0, 0);
    cyc(BASE, 32'h77, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(BASE + 32'h1, 32'h88 + 32'h11 * i, 1, 0, 1, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 1, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 1, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 0, 0, 0);
    cyc(BASE + 32'h8, 0, 0, 0, 0, 32'hA5, 1);
    cyc(BASE + 32'h8, 0, 0, 0, 0, 32'h5A, 1);
    cyc(BASE + 32'h8, 0, 0, 0, 0, 0, 0);
    cyc(BASE + 32'h4, 0, 0, 1, 0, 0, 0);
    cyc(BASE + 32'h4, 32'h8, 1, 0, 0, 0, 0);
    cyc(BASE + 32'h4, 0, 0, 1, 0, 0, 0);
    cyc(BASE + 32'h8, 0, 0, 1, 0, 32'hBEEF, 1);
    cyc(BASE + 32'h4, 0, 0, 1, 0, 0, 0);
    cyc(BASE + 32'hA, 0, 0, 0, 0, 0, 0);
    cyc(32'h0000_0000, 32'h1234, 1, 1, 0, 0, 0);
    cyc(BASE + 32'h10, 32'h1234, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(BASE, 32'hC0 + i, 1, 0, 0, 0, 0);
    do_reset();
    cyc(BASE, 32'hD0, 1, 0, 0, 0, 0);
    cyc(BASE + 32'hC, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 8) a = BASE + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      else a = $urandom;
      cyc(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
      if (i == 300) do_reset();
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk_t);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
